serial_adder: RTL and testbench



---
 rtl/lab_pkg.sv | 18 +
 rtl/serial_adder_if.sv | 27 ++
 rtl/fa_vr.sv | 15 +
 rtl/serial_adder.sv | 116 +++++++++++
 tb/tb_serial_adder.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/lab_pkg.sv
// Shared lab datapath definitions: FSM state encoding and default operand width.
package lab_pkg;

    localparam int ADD_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Operand B as fed to the cell: inverted for subtraction (the +1 comes from carry-in).
    function automatic logic [ADD_W-1:0] cond_invert(input logic [ADD_W-1:0] val,
                                                     input logic             inv);
        return inv ? ~val : val;
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Start/done handshake and operand/result bus of the bit-serial adder.
interface serial_adder_if
    import lab_pkg::*;
#(
    parameter int N = ADD_W
);
    logic         i_start;
    logic         i_sub;
    logic [N-1:0] i_a;
    logic [N-1:0] i_b;
    logic         o_busy;
    logic         o_done;
    logic [N-1:0] o_sum;
    logic         o_c_out;
    logic         o_overflow;

    modport master (
        output i_start, i_sub, i_a, i_b,
        input  o_busy, o_done, o_sum, o_c_out, o_overflow
    );

    modport slave (
        input  i_start, i_sub, i_a, i_b,
        output o_busy, o_done, o_sum, o_c_out, o_overflow
    );

endinterface

// File: rtl/fa_vr.sv
// One-bit full-adder cell, gate-level form.
module fa_vr (
    output logic sum,
    output logic c_out,
    input  logic a,
    input  logic b,
    input  logic c_in
);
    logic w_axb;

    assign w_axb = a ^ b;
    assign sum   = w_axb ^ c_in;
    assign c_out = (a & b) | (c_in & w_axb);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder/subtractor: one full-adder cell plus a carry flop, LSB first,
// N RUN cycles per operation, results published on the last RUN edge.
module serial_adder
    import lab_pkg::*;
#(
    parameter int N = ADD_W
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);
    localparam int            CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        r_state;
    state_t        w_state_next;
    logic          w_accept;
    logic          w_last;
    logic          w_busy;
    logic          w_done;

    logic [N-1:0]  r_shift_a;
    logic [N-1:0]  r_shift_b;
    logic [N-1:0]  r_acc;
    logic [N-1:0]  r_sum;
    logic          r_carry;
    logic          r_c_out;
    logic          r_overflow;
    logic [CW-1:0] r_count;

    logic          w_fa_sum;
    logic          w_fa_cout;

    fa_vr u_fa (
        .sum   (w_fa_sum),
        .c_out (w_fa_cout),
        .a     (r_shift_a[0]),
        .b     (r_shift_b[0]),
        .c_in  (r_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.i_start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (r_count == LAST) begin
                    w_last       = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // r_acc collects bits as they are produced; r_sum only changes on the final edge
    // so the previous result stays visible throughout a new operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift_a  <= '0;
            r_shift_b  <= '0;
            r_acc      <= '0;
            r_sum      <= '0;
            r_carry    <= 1'b0;
            r_c_out    <= 1'b0;
            r_overflow <= 1'b0;
            r_count    <= '0;
        end else if (w_accept) begin
            r_shift_a <= bus.i_a;
            r_shift_b <= bus.i_sub ? ~bus.i_b : bus.i_b;
            r_carry   <= bus.i_sub;
            r_count   <= '0;
        end else if (r_state == S_RUN) begin
            r_shift_a <= {1'b0, r_shift_a[N-1:1]};
            r_shift_b <= {1'b0, r_shift_b[N-1:1]};
            r_acc     <= {w_fa_sum, r_acc[N-1:1]};
            r_carry   <= w_fa_cout;
            r_count   <= r_count + 1'b1;
            if (w_last) begin
                // r_carry is the carry into the MSB at this point.
                r_sum      <= {w_fa_sum, r_acc[N-1:1]};
                r_c_out    <= w_fa_cout;
                r_overflow <= r_carry ^ w_fa_cout;
            end
        end
    end

    assign bus.o_busy     = w_busy;
    assign bus.o_done     = w_done;
    assign bus.o_sum      = r_sum;
    assign bus.o_c_out    = r_c_out;
    assign bus.o_overflow = r_overflow;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (N = 8).
module tb_serial_adder;

    localparam int N = lab_pkg::ADD_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    serial_adder_if #(.N(N)) bus ();

    serial_adder #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation; pulse_at > 0 raises start again that many edges after acceptance.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic s, input int pulse_at,
                          input logic [7:0] e_sum, input logic e_c, input logic e_ov);
        int   cycles;
        int   extra_done;
        logic busy_ok;
        bus.i_a     = a;
        bus.i_b     = b;
        bus.i_sub   = s;
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        bus.i_a     = 8'hAA;
        bus.i_b     = 8'h55;
        bus.i_sub   = ~s;
        check({tag, "_busy_after_accept"}, 32'(bus.o_busy), 32'd1);
        cycles  = 0;
        busy_ok = 1'b1;
        while (!bus.o_done && cycles < 3 * N) begin
            bus.i_start = (pulse_at > 0 && cycles == pulse_at - 1);
            tick();
            cycles++;
            if (!bus.o_done && !bus.o_busy) busy_ok = 1'b0;
        end
        bus.i_start = 1'b0;
        check({tag, "_latency"}, 32'(cycles), 32'(N));
        check({tag, "_busy_held"}, 32'(busy_ok), 32'd1);
        check({tag, "_busy_in_done"}, 32'(bus.o_busy), 32'd0);
        check({tag, "_sum"}, 32'(bus.o_sum), 32'(e_sum));
        check({tag, "_c_out"}, 32'(bus.o_c_out), 32'(e_c));
        check({tag, "_overflow"}, 32'(bus.o_overflow), 32'(e_ov));
        tick();
        check({tag, "_done_one_cycle"}, 32'(bus.o_done), 32'd0);
        if (pulse_at > 0) begin
            extra_done = 0;
            for (int i = 0; i < N + 2; i++) begin
                tick();
                if (bus.o_done) extra_done++;
            end
            check({tag, "_no_second_done"}, 32'(extra_done), 32'd0);
            check({tag, "_sum_kept"}, 32'(bus.o_sum), 32'(e_sum));
        end
        $display("op %s: a=0x%02h b=0x%02h sub=%0d -> sum=0x%02h c=%0d ov=%0d",
                 tag, a, b, s, bus.o_sum, bus.o_c_out, bus.o_overflow);
    endtask

    initial begin
        int dones;
        bus.i_start = 1'b0;
        bus.i_sub   = 1'b0;
        bus.i_a     = '0;
        bus.i_b     = '0;
        #2;
        check("rst_busy", 32'(bus.o_busy), 32'd0);
        check("rst_done", 32'(bus.o_done), 32'd0);
        check("rst_sum", 32'(bus.o_sum), 32'd0);
        check("rst_c_out", 32'(bus.o_c_out), 32'd0);
        check("rst_overflow", 32'(bus.o_overflow), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        // Reset pulse while idle, asserted between edges.
        #2 rst = 1'b1;
        #1 check("rst_idle_busy", 32'(bus.o_busy), 32'd0);
        bus.i_start = 1'b1;
        tick();
        check("rst_beats_start", 32'(bus.o_busy), 32'd0);
        bus.i_start = 1'b0;
        rst = 1'b0;
        tick();

        run_op("zero", 8'h00, 8'h00, 1'b0, 0, 8'h00, 1'b0, 1'b0);
        run_op("wrap", 8'hFF, 8'h01, 1'b0, 0, 8'h00, 1'b1, 1'b0);
        run_op("sub_borrow", 8'h05, 8'h07, 1'b1, 0, 8'hFE, 1'b0, 1'b0);
        run_op("sub_noborrow", 8'h07, 8'h05, 1'b1, 0, 8'h02, 1'b1, 1'b0);
        run_op("start_ignored", 8'h10, 8'h20, 1'b0, 3, 8'h30, 1'b0, 1'b0);
        run_op("ovf_pos", 8'h7F, 8'h01, 1'b0, 0, 8'h80, 1'b0, 1'b1);
        run_op("ovf_neg", 8'h80, 8'hFF, 1'b0, 0, 8'h7F, 1'b1, 1'b1);

        // Abort mid-operation.
        bus.i_a     = 8'h3C;
        bus.i_b     = 8'h0F;
        bus.i_sub   = 1'b0;
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("abort_busy_before", 32'(bus.o_busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(bus.o_busy), 32'd0);
        check("abort_done", 32'(bus.o_done), 32'd0);
        check("abort_sum", 32'(bus.o_sum), 32'd0);
        check("abort_c_out", 32'(bus.o_c_out), 32'd0);
        check("abort_overflow", 32'(bus.o_overflow), 32'd0);
        tick();
        rst   = 1'b0;
        dones = 0;
        for (int i = 0; i < N + 2; i++) begin
            tick();
            if (bus.o_done || bus.o_busy) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        run_op("after_abort", 8'h01, 8'h02, 1'b0, 0, 8'h03, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
